// File: rtl/cdc_hs_tx.sv
// Source side of a 4-phase req/ack handshake that launches one word across a clock-domain boundary.
// Optional sticky OVERFLOW output for dropped words is enabled with `define CDC_HS_TX_OVF_EN.
module cdc_hs_tx #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] DATA_IN,
  input  logic                 DATA_VALID,
  output logic                 BUSY,
  output logic [BUS_WIDTH-1:0] TX_DATA,
  output logic                 TX_REQ,
  input  logic                 TX_ACK,
  output logic                 DONE
`ifdef CDC_HS_TX_OVF_EN
  ,
  output logic                 OVERFLOW
`endif
);

  // state  | meaning
  // IDLE   | waiting for DATA_VALID; last word held on TX_DATA
  // SETUP  | TX_DATA settling one cycle ahead of the request
  // REQ_HI | TX_REQ high, waiting for synchronized ACK to rise
  // REQ_LO | TX_REQ low, waiting for synchronized ACK to fall
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    REQ_HI = 2'd2,
    REQ_LO = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_STAGES-1:0] ack_ff;
  logic                  ack_sync;
  logic                  load_d;
  logic                  done_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ack_ff <= '0;
    else     ack_ff <= {ack_ff[NUM_STAGES-2:0], TX_ACK};
  end

  assign ack_sync = ack_ff[NUM_STAGES-1];

  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (DATA_VALID) begin
          state_d = SETUP;
          load_d  = 1'b1;
        end
      end
      SETUP:   state_d = REQ_HI;
      REQ_HI:  if (ack_sync) state_d = REQ_LO;
      REQ_LO: begin
        if (!ack_sync) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      TX_DATA <= '0;
      TX_REQ  <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      TX_REQ  <= (state_d == REQ_HI);
      BUSY    <= (state_d != IDLE);
      DONE    <= done_d;
      if (load_d) TX_DATA <= DATA_IN;
    end
  end

`ifdef CDC_HS_TX_OVF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                    OVERFLOW <= 1'b0;
    else if (DATA_VALID && BUSY) OVERFLOW <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed plus randomized bench for cdc_hs_tx; the destination side is modelled by the bench itself.
// Define CDC_HS_TX_OVF_EN for both files to also check the OVERFLOW flag.
module tb_cdc_hs_tx;
  localparam int BW  = 8;
  localparam int NS  = 2;
  // Edges from an ACK change until the source reacts: NS to synchronize, one to register.
  localparam int LAT = NS + 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic [BW-1:0] DATA_IN;
  logic          DATA_VALID;
  logic          BUSY;
  logic [BW-1:0] TX_DATA;
  logic          TX_REQ;
  logic          TX_ACK;
  logic          DONE;
`ifdef CDC_HS_TX_OVF_EN
  logic          OVERFLOW;
  logic          ovf_exp;
`endif

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int req_toggles = 0;
  logic req_prev = 1'b0;

  cdc_hs_tx #(.BUS_WIDTH(BW), .NUM_STAGES(NS)) dut (
    .CLK(CLK),
    .RST(RST),
    .DATA_IN(DATA_IN),
    .DATA_VALID(DATA_VALID),
    .BUSY(BUSY),
    .TX_DATA(TX_DATA),
    .TX_REQ(TX_REQ),
    .TX_ACK(TX_ACK),
    .DONE(DONE)
`ifdef CDC_HS_TX_OVF_EN
    ,
    .OVERFLOW(OVERFLOW)
`endif
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (DONE === 1'b1) done_cnt++;
    if (TX_REQ !== req_prev) req_toggles++;
    req_prev = TX_REQ;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input logic v);
    int n = 0;
    while (TX_REQ !== v && n < 50) begin
      tick();
      n++;
    end
    check("wait_req", {31'd0, TX_REQ}, {31'd0, v});
  endtask

  task automatic wait_done();
    int n = 0;
    while (DONE !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("wait_done", {31'd0, DONE}, 32'd1);
  endtask

  task automatic handshake();
    wait_req(1'b1);
    TX_ACK = 1'b1;
    wait_req(1'b0);
    TX_ACK = 1'b0;
    wait_done();
  endtask

  initial begin
    int d0, t0;
    logic [BW-1:0] word, junk;
    logic junk_v;
    int gap;

    RST = 1'b1; DATA_IN = '0; DATA_VALID = 1'b0; TX_ACK = 1'b0;
    tick(); tick();
    check("rst_req",  {31'd0, TX_REQ}, 32'd0);
    check("rst_data", {24'd0, TX_DATA}, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_done", {31'd0, DONE}, 32'd0);
`ifdef CDC_HS_TX_OVF_EN
    check("rst_ovf", {31'd0, OVERFLOW}, 32'd0);
`endif
    RST = 1'b0;
    tick();

    // Basic transfer with edge-by-edge timing.
    DATA_IN = 8'hA5; DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    check("basic_data_e0", {24'd0, TX_DATA}, 32'hA5);
    check("basic_req_e0",  {31'd0, TX_REQ}, 32'd0);
    check("basic_busy_e0", {31'd0, BUSY}, 32'd1);
    tick();
    check("basic_req_e1", {31'd0, TX_REQ}, 32'd1);
    TX_ACK = 1'b1;
    tick(); check("basic_req_e2", {31'd0, TX_REQ}, 32'd1);
    tick(); check("basic_req_e3", {31'd0, TX_REQ}, 32'd1);
    tick(); check("basic_req_e4", {31'd0, TX_REQ}, 32'd0);
    TX_ACK = 1'b0;
    tick(); check("basic_done_e5", {31'd0, DONE}, 32'd0);
    tick(); check("basic_done_e6", {31'd0, DONE}, 32'd0);
    check("basic_busy_e6", {31'd0, BUSY}, 32'd1);
    tick(); check("basic_done_e7", {31'd0, DONE}, 32'd1);
    check("basic_busy_e7", {31'd0, BUSY}, 32'd0);
    tick(); check("basic_done_e8", {31'd0, DONE}, 32'd0);
    check("basic_hold", {24'd0, TX_DATA}, 32'hA5);

    // Back-to-back with DATA_VALID held high.
    d0 = done_cnt;
    DATA_IN = 8'h11; DATA_VALID = 1'b1;
    tick();
    check("b2b_first", {24'd0, TX_DATA}, 32'h11);
    DATA_IN = 8'h22;
    handshake();
    check("b2b_data_at_done", {24'd0, TX_DATA}, 32'h11);
    check("b2b_busy_at_done", {31'd0, BUSY}, 32'd0);
    tick();
    check("b2b_second", {24'd0, TX_DATA}, 32'h22);
    check("b2b_busy2", {31'd0, BUSY}, 32'd1);
    DATA_VALID = 1'b0;
    handshake();
    tick(); tick();
    check("b2b_done_count", done_cnt - d0, 32'd2);
`ifdef CDC_HS_TX_OVF_EN
    check("b2b_ovf", {31'd0, OVERFLOW}, 32'd1);
`endif

    // Word offered during REQ_HI is dropped.
    RST = 1'b1; tick(); RST = 1'b0; tick();
    DATA_IN = 8'h5A; DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    wait_req(1'b1);
    DATA_IN = 8'h3C; DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    check("drop_data", {24'd0, TX_DATA}, 32'h5A);
`ifdef CDC_HS_TX_OVF_EN
    check("drop_ovf", {31'd0, OVERFLOW}, 32'd1);
`endif
    handshake();
    tick();
    check("drop_data_after", {24'd0, TX_DATA}, 32'h5A);
    check("drop_idle", {31'd0, BUSY}, 32'd0);

    // ACK already high before accept.
    TX_ACK = 1'b1;
    tick(); tick(); tick();
    check("stuck_idle_req", {31'd0, TX_REQ}, 32'd0);
    DATA_IN = 8'h77; DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    check("stuck_setup_req", {31'd0, TX_REQ}, 32'd0);
    tick();
    check("stuck_reqhi", {31'd0, TX_REQ}, 32'd1);
    tick();
    check("stuck_req_drop", {31'd0, TX_REQ}, 32'd0);
    d0 = done_cnt;
    tick(); tick(); tick();
    check("stuck_no_done", done_cnt - d0, 32'd0);
    TX_ACK = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      check("stuck_done", {31'd0, DONE}, (k == LAT) ? 32'd1 : 32'd0);
    end

    // Reset during REQ_LO.
    tick();
    DATA_IN = 8'h99; DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    wait_req(1'b1);
    TX_ACK = 1'b1;
    wait_req(1'b0);
    d0 = done_cnt;
    #2;
    RST = 1'b1;
    #1;
    check("rstmid_req",  {31'd0, TX_REQ}, 32'd0);
    check("rstmid_data", {24'd0, TX_DATA}, 32'd0);
    check("rstmid_busy", {31'd0, BUSY}, 32'd0);
    tick(); tick();
    RST = 1'b0;
    TX_ACK = 1'b0;
    tick(); tick();
    check("rstmid_no_done", done_cnt - d0, 32'd0);
`ifdef CDC_HS_TX_OVF_EN
    check("rstmid_ovf", {31'd0, OVERFLOW}, 32'd0);
`endif
    DATA_IN = 8'h42; DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    check("rstmid_accept", {24'd0, TX_DATA}, 32'h42);
    check("rstmid_busy2", {31'd0, BUSY}, 32'd1);
    handshake();
    tick();

    // One-cycle ACK pulse in REQ_HI.
    DATA_IN = 8'h5E; DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    wait_req(1'b1);
    tick(); tick();
    t0 = req_toggles;
    d0 = done_cnt;
    TX_ACK = 1'b1;
    tick();
    TX_ACK = 1'b0;
    for (int k = 2; k <= NS + 2; k++) begin
      tick();
      check("glitch_req", {31'd0, TX_REQ}, (k <= NS) ? 32'd1 : 32'd0);
      check("glitch_done", {31'd0, DONE}, (k == NS + 2) ? 32'd1 : 32'd0);
    end
    tick(); tick(); tick();
    check("glitch_toggles", req_toggles - t0, 32'd1);
    check("glitch_done_cnt", done_cnt - d0, 32'd1);

    // Randomized transfers against the timing model.
    RST = 1'b1; tick(); RST = 1'b0; tick();
`ifdef CDC_HS_TX_OVF_EN
    ovf_exp = 1'b0;
`endif
    for (int t = 0; t < 20; t++) begin
      word = BW'($urandom);
      DATA_IN = word; DATA_VALID = 1'b1;
      tick();
      check("rnd_accept", {24'd0, TX_DATA}, {24'd0, word});
      junk_v = 1'($urandom);
      junk = BW'($urandom);
      DATA_VALID = junk_v; DATA_IN = junk;
`ifdef CDC_HS_TX_OVF_EN
      ovf_exp = ovf_exp | junk_v;
`endif
      tick();
      check("rnd_req_up", {31'd0, TX_REQ}, 32'd1);
      gap = $urandom_range(0, 5);
      for (int i = 0; i < gap; i++) begin
        tick();
        check("rnd_req_hold", {31'd0, TX_REQ}, 32'd1);
      end
      TX_ACK = 1'b1;
      for (int k = 1; k <= LAT; k++) begin
        tick();
        check("rnd_req_fall", {31'd0, TX_REQ}, (k < LAT) ? 32'd1 : 32'd0);
      end
      DATA_VALID = 1'b0;
      gap = $urandom_range(0, 5);
      for (int i = 0; i < gap; i++) begin
        tick();
        check("rnd_busy_wait", {31'd0, BUSY}, 32'd1);
      end
      TX_ACK = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
        tick();
        check("rnd_done", {31'd0, DONE}, (k == LAT) ? 32'd1 : 32'd0);
        check("rnd_busy", {31'd0, BUSY}, (k == LAT) ? 32'd0 : 32'd1);
      end
      check("rnd_data_kept", {24'd0, TX_DATA}, {24'd0, word});
`ifdef CDC_HS_TX_OVF_EN
      check("rnd_ovf", {31'd0, OVERFLOW}, {31'd0, ovf_exp});
`endif
      gap = $urandom_range(1, 3);
      for (int i = 0; i < gap; i++) tick();
      check("rnd_idle_done", {31'd0, DONE}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cdc_hs_tx.md
CDC_HS_TX -- requirements
Module: cdc_hs_tx

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 8, meaning width of the transferred data word.
REQ-002 The block SHALL have parameter NUM_STAGES, default 2, meaning number of synchronizer flops on the returning acknowledge (legal range >= 2).
REQ-003 The block SHALL have port CLK  input  1  meaning source-domain clock, all state on posedge.
REQ-004 The block SHALL have port RST  input  1  meaning asynchronous, active-high reset.
REQ-005 The block SHALL have port DATA_IN  input  BUS_WIDTH  meaning word to transfer, sampled on accept.
REQ-006 The block SHALL have port DATA_VALID  input  1  meaning request to launch DATA_IN.
REQ-007 The block SHALL have port BUSY  output  1  meaning transfer in progress; new words are not accepted.
REQ-008 The block SHALL have port TX_DATA  output  BUS_WIDTH  meaning registered bus presented to the destination domain.
REQ-009 The block SHALL have port TX_REQ  output  1  meaning registered 4-phase request to the destination domain.
REQ-010 The block SHALL have port TX_ACK  input  1  meaning asynchronous acknowledge from the destination domain.
REQ-011 The block SHALL have port DONE  output  1  meaning single-cycle pulse marking handshake completion.

Function
REQ-012 The block SHALL pass TX_ACK through a NUM_STAGES-flop shift synchronizer (ack_sync = last stage); the FSM SHALL use only ack_sync.
REQ-013 The FSM SHALL have states IDLE, SETUP, REQ_HI and REQ_LO.
REQ-014 Accept: in IDLE with DATA_VALID=1, the block SHALL register DATA_IN into TX_DATA and move to SETUP on that edge.
REQ-015 SETUP SHALL last exactly one cycle, then move to REQ_HI with TX_REQ=1, so TX_DATA is stable at least one cycle before TX_REQ rises.
REQ-016 In REQ_HI with ack_sync=1, the block SHALL drive TX_REQ=0 and move to REQ_LO; otherwise it SHALL hold.
REQ-017 In REQ_LO with ack_sync=0, the block SHALL pulse DONE=1 for one cycle and return to IDLE; otherwise it SHALL hold.
REQ-018 BUSY SHALL be 1 in every state except IDLE (registered, state-decoded), so a word can be accepted the cycle after DONE.
REQ-019 The block SHALL hold TX_DATA constant from accept until the next accept; it SHALL retain the last word while in IDLE.
REQ-020 The block SHALL ignore DATA_VALID while BUSY=1, with no effect on TX_DATA or the FSM.
REQ-021 The block SHALL ignore ack_sync=1 while in IDLE or SETUP (stuck or spurious ACK); REQ_HI SHALL still be entered.
REQ-022 No timeout SHALL exist; the FSM SHALL wait indefinitely on ack_sync.

Reset
REQ-023 RST=1 SHALL asynchronously force: state IDLE, all synchronizer flops 0, TX_REQ 0, TX_DATA 0, DONE 0, BUSY 0.
REQ-024 RST asserted mid-handshake SHALL abort the transfer with no DONE pulse; after release the block SHALL accept on the first valid edge.

Configuration
REQ-025 The block SHALL support macro CDC_HS_TX_OVF_EN; when it is defined, an output port OVERFLOW (1 bit) SHALL exist.
REQ-026 With CDC_HS_TX_OVF_EN defined, OVERFLOW SHALL be a sticky flag, set on any edge where DATA_VALID=1 and BUSY=1, and cleared only by RST.
REQ-027 Without CDC_HS_TX_OVF_EN, no OVERFLOW port or logic SHALL exist; dropped words are silent, with otherwise identical behaviour.

Verification
REQ-028 Bench SHALL cover basic transfer, NUM_STAGES=2: DATA_IN=0xA5, DATA_VALID pulse at edge 0 -> TX_DATA=0xA5 after edge 0; TX_REQ=1 after edge 1; TX_ACK raised after edge 1 -> TX_REQ=0 after edge 4; TX_ACK dropped after edge 4 -> DONE=1 for the single cycle after edge 7; BUSY=0 after edge 7.
REQ-029 Bench SHALL cover back-to-back transfer: 0x11 then 0x22 with DATA_VALID held high -> second accept on the first edge with BUSY=0; TX_DATA=0x22; exactly two DONE pulses.
REQ-030 Bench SHALL cover drop while busy: DATA_VALID=1 with DATA_IN=0x3C during REQ_HI -> TX_DATA unchanged; OVERFLOW=1 only when the macro is defined.
REQ-031 Bench SHALL cover stuck ACK: TX_ACK=1 before accept -> REQ_HI entered, TX_REQ drops NUM_STAGES-1 or fewer cycles later; DONE only after ACK returns to 0.
REQ-032 Bench SHALL cover reset mid-operation: RST=1 during REQ_LO -> TX_REQ=0, TX_DATA=0x00, BUSY=0 immediately, with no DONE pulse.
REQ-033 Bench SHALL cover ACK glitch: a 1-cycle TX_ACK pulse shorter than the synchronizer depth in REQ_HI -> a glitch fully sampled by the flops propagates; the bench SHALL check that TX_REQ never toggles more than once per ack_sync edge.
